// File: rtl/spi_dac_receiver.sv
// SPI slave model of the MCP4911 DAC end of the spi2dac link: synchronises the
// four SPI pins onto sysclk, decodes 16-bit frames and presents the loaded sample.
module spi_dac_receiver #(
    parameter int         FRAME_BITS  = 16,
    parameter logic [3:0] EXPECT_CTRL = 4'b0011,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       sdi,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       ld_n,
    output logic [9:0] dac_value,
    output logic [3:0] ctrl,
    output logic       load_pulse,
    output logic       frame_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sdi_sync, sck_sync, cs_sync, ld_sync;
    logic                   sdi_q, sck_q, cs_q, ld_q;
    logic                   sck_rise, cs_rise, ld_fall;

    logic [FRAME_BITS-1:0]  shreg;
    logic [4:0]             bit_cnt;
    logic [13:0]            hold;
    logic                   pending;

    logic                   frame_ok;
    logic                   check_valid;
    logic                   check_bad;
    logic [13:0]            load_src;

    // Synchronisers preload to the idle bus so reset release never fakes a cs_n or ld_n edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sdi_sync <= '0;
            sck_sync <= '0;
            cs_sync  <= '1;
            ld_sync  <= '1;
            sdi_q    <= 1'b0;
            sck_q    <= 1'b0;
            cs_q     <= 1'b1;
            ld_q     <= 1'b1;
            sck_rise <= 1'b0;
            cs_rise  <= 1'b0;
            ld_fall  <= 1'b0;
        end else begin
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            ld_sync  <= {ld_sync[SYNC_STAGES-2:0], ld_n};
            sdi_q    <= sdi_sync[SYNC_STAGES-1];
            sck_q    <= sck_sync[SYNC_STAGES-1];
            cs_q     <= cs_sync[SYNC_STAGES-1];
            ld_q     <= ld_sync[SYNC_STAGES-1];
            sck_rise <= ~sck_q & sck_sync[SYNC_STAGES-1];
            cs_rise  <= ~cs_q & cs_sync[SYNC_STAGES-1];
            ld_fall  <= ld_q & ~ld_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!cs_q) state_next = SHIFT;
            SHIFT:   if (cs_rise) state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign frame_ok    = (bit_cnt == 5'(FRAME_BITS)) && (shreg[15:12] == EXPECT_CTRL);
    assign check_valid = (state == CHECK) && frame_ok;
    assign check_bad   = (state == CHECK) && !frame_ok;
    // A frame validated this very cycle outranks whatever is waiting in hold.
    assign load_src    = check_valid ? shreg[15:2] : hold;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            hold       <= '0;
            pending    <= 1'b0;
            dac_value  <= '0;
            ctrl       <= '0;
            load_pulse <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            load_pulse <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE && !cs_q) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (state == SHIFT && !cs_rise && sck_rise && !cs_q) begin
                shreg <= {shreg[FRAME_BITS-2:0], sdi_q};
                if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            end

            if (check_valid) hold <= shreg[15:2];

            if (check_bad) begin
                frame_err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end

            if (ld_fall && (check_valid || pending)) begin
                dac_value  <= load_src[9:0];
                ctrl       <= load_src[13:10];
                load_pulse <= 1'b1;
                pending    <= 1'b0;
            end else if (check_valid) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Bench for spi_dac_receiver: bit-banged SPI frames checked against a frame-level
// model of the DAC register (hold/pending/output/error count).
module tb_spi_dac_receiver;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       sdi, sck, cs_n, ld_n;
    logic [9:0] dac_value;
    logic [3:0] ctrl;
    logic       load_pulse, frame_err;
    logic [7:0] err_count;

    spi_dac_receiver dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .sdi        (sdi),
        .sck        (sck),
        .cs_n       (cs_n),
        .ld_n       (ld_n),
        .dac_value  (dac_value),
        .ctrl       (ctrl),
        .load_pulse (load_pulse),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    always #10 sysclk = ~sysclk;

    int n_checks = 0;
    int n_fail   = 0;
    int load_seen = 0;
    int err_seen  = 0;

    // Frame-level model of the DAC input/output registers.
    logic [15:0] m_hold;
    bit          m_pending;
    logic [9:0]  m_dac;
    logic [3:0]  m_ctrl;
    int          m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge sysclk) begin
        if (load_pulse === 1'b1) load_seen++;
        if (frame_err === 1'b1)  err_seen++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic model_load();
        if (m_pending) begin
            m_dac     = m_hold[11:2];
            m_ctrl    = m_hold[15:12];
            m_pending = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".dac"},  32'(dac_value), 32'(m_dac));
        check({tag, ".ctrl"}, 32'(ctrl),      32'(m_ctrl));
        check({tag, ".errc"}, 32'(err_count), 32'(m_err));
    endtask

    // Shift nbits of word MSB first, SCK = sysclk/8; optionally drop ld_n one cycle after cs_n rises.
    task automatic send_frame(input logic [31:0] word, input int nbits, input bit ld_same);
        int  e0, l0;
        bit  valid, exp_load;
        e0 = err_seen;
        l0 = load_seen;
        cs_n = 1'b0;
        cyc(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = word[i];
            sck = 1'b0;
            cyc(4);
            sck = 1'b1;
            cyc(4);
        end
        sck = 1'b0;
        cyc(4);
        cs_n = 1'b1;
        if (ld_same) begin
            cyc(1);
            ld_n = 1'b0;
            cyc(2);
            ld_n = 1'b1;
            cyc(7);
        end else begin
            cyc(8);
        end
        valid = (nbits == 16) && (word[15:12] == 4'b0011);
        if (valid) begin
            m_hold    = word[15:0];
            m_pending = 1'b1;
        end else if (m_err < 255) begin
            m_err++;
        end
        exp_load = ld_same && m_pending;
        if (ld_same) model_load();
        check("frame_err_pulses", 32'(err_seen - e0), valid ? 32'd0 : 32'd1);
        check("frame_load_pulses", 32'(load_seen - l0), exp_load ? 32'd1 : 32'd0);
        check("frame_err_count", 32'(err_count), 32'(m_err));
    endtask

    task automatic pulse_ld(input string tag);
        int l0;
        bit exp_load;
        l0 = load_seen;
        exp_load = m_pending;
        ld_n = 1'b0;
        cyc(2);
        ld_n = 1'b1;
        cyc(8);
        model_load();
        check({tag, ".pulses"}, 32'(load_seen - l0), exp_load ? 32'd1 : 32'd0);
        check({tag, ".dac"},    32'(dac_value), 32'(m_dac));
        check({tag, ".ctrl"},   32'(ctrl),      32'(m_ctrl));
    endtask

    initial begin
        int          n;
        logic [31:0] w;
        int          nb;
        logic [3:0]  c;

        rst = 1'b1; sdi = 1'b0; sck = 1'b0; cs_n = 1'b1; ld_n = 1'b1;
        m_hold = '0; m_pending = 1'b0; m_dac = '0; m_ctrl = '0; m_err = 0;
        cyc(3);
        check("rst.load_pulse", 32'(load_pulse), 32'd0);
        check("rst.frame_err",  32'(frame_err),  32'd0);
        check_outputs("rst");
        rst = 1'b0;
        cyc(4);

        // Basic frame, with ld_n pin-to-pulse latency measured.
        send_frame(32'h3A5C, 16, 1'b0);
        n = 0;
        ld_n = 1'b0;
        while (load_pulse !== 1'b1 && n < 20) begin
            @(posedge sysclk);
            #1;
            n++;
        end
        check("ld_latency", 32'(n), 32'd4);
        cyc(2);
        ld_n = 1'b1;
        cyc(6);
        model_load();
        check("t1.dac",  32'(dac_value), 32'h297);
        check("t1.ctrl", 32'(ctrl), 32'h3);
        check_outputs("t1");

        // Short frame, then bad control nibble followed by an ignored load.
        send_frame(32'h3A5C, 15, 1'b0);
        check_outputs("t2");
        send_frame(32'hBA5C, 16, 1'b0);
        pulse_ld("t3");

        // Two frames before one load: last wins; second load does nothing.
        send_frame(32'h3300, 16, 1'b0);
        send_frame(32'h33FC, 16, 1'b0);
        pulse_ld("t4a");
        check("t4.dac", 32'(dac_value), 32'h0FF);
        pulse_ld("t4b");

        // ld_n fall coinciding with the CHECK cycle.
        send_frame(32'h3123, 16, 1'b1);
        check_outputs("prio");

        // Random frames and loads.
        for (int k = 0; k < 40; k++) begin
            n  = $urandom_range(0, 5);
            nb = (n == 0) ? 15 : (n == 1) ? 17 : 16;
            c  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0011;
            w  = {15'($urandom), 1'($urandom), c, 12'($urandom)};
            send_frame(w, nb, 1'b0);
            if ($urandom_range(0, 1) == 1) pulse_ld("rnd");
        end

        // Reset in the middle of a frame.
        cs_n = 1'b0;
        cyc(4);
        for (int i = 0; i < 8; i++) begin
            sdi = 1'($urandom);
            sck = 1'b0; cyc(4);
            sck = 1'b1; cyc(4);
        end
        rst = 1'b1;
        cyc(1);
        sck = 1'b0; cs_n = 1'b1;
        cyc(2);
        m_hold = '0; m_pending = 1'b0; m_dac = '0; m_ctrl = '0; m_err = 0;
        check("t5.load_pulse", 32'(load_pulse), 32'd0);
        check_outputs("t5rst");
        rst = 1'b0;
        cyc(4);
        send_frame(32'h3B44, 16, 1'b0);
        pulse_ld("t5");

        // Error counter saturation.
        for (int k = 0; k < 300; k++) send_frame(32'h0, 2, 1'b0);
        check("t6.sat", 32'(err_count), 32'd255);

        // Ramp over the full code range (every third code keeps the run short).
        for (int v = 0; v <= 1023; v += 3) begin
            send_frame({16'h0, 4'b0011, 10'(v), 2'b00}, 16, 1'b0);
            pulse_ld("ramp");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
